display_scan_ctrl: RTL

Time-multiplexed scan controller for the shared 4-bit-to-7-segment `display` decoder. Holds a multi-digit hex value and, one digit at a time, drives that digit's nibble onto the decoder inputs `S0..S3` and enables the matching digit's common line. New values arrive over a valid/ready handshake and are applied only at a frame boundary, so one frame never mixes old and new digits. Inserts a blanking gap before each digit to suppress ghosting.

---
 rtl/display_scan_ctrl_if.sv | 21 ++
 rtl/display_scan_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl_if.sv
// Load handshake bundle for the display scan controller.
// The source holds load_valid until it sees load_ready.
interface display_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-seg scan controller: per-digit BLANK/SHOW
// slots, one queued load applied only at a frame boundary.
module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_ctrl_if.slave  load_if,
  input  logic [DIGITS-1:0]   blank_mask,
  output logic                S0,
  output logic                S1,
  output logic                S2,
  output logic                S3,
  output logic [DIGITS-1:0]   dig_en,
  output logic                frame_done
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ?
                        REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW   = 4 * DIGITS;

  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [VW-1:0]     active_q, active_d;
  logic [VW-1:0]     pending_q, pending_d;
  logic              pend_v_q, pend_v_d;
  logic              ready_q, ready_d;
  logic [3:0]        nib_q, nib_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              fd_q, fd_d;

  logic              accept;
  logic              boundary;

  assign accept   = load_if.load_valid && ready_q;
  assign boundary = (state_q == ST_SHOW) &&
                    (dig_q == D_LAST) &&
                    (cnt_q == R_LAST);

  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q + CW'(1);
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == B_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == R_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (dig_q == D_LAST) begin
            dig_d = '0;
          end else begin
            dig_d = dig_q + DW'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // accept needs an empty queue, so it never collides with the swap
    if (boundary && pend_v_q) begin
      active_d = pending_q;
      pend_v_d = 1'b0;
    end
    if (accept) begin
      pending_d = load_if.load_data;
      pend_v_d  = 1'b1;
    end
  end

  always_comb begin
    ready_d = !pend_v_d;
    nib_d   = '0;
    sel_d   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_d == DW'(k)) begin
        nib_d = active_d[4*k +: 4];
      end
      sel_d[k] = (state_d == ST_SHOW) && (dig_d == DW'(k));
    end
    fd_d = (state_d == ST_SHOW) &&
           (dig_d == D_LAST) &&
           (cnt_d == R_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      dig_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      ready_q   <= 1'b1;
      nib_q     <= '0;
      sel_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      ready_q   <= ready_d;
      nib_q     <= nib_d;
      sel_q     <= sel_d;
      fd_q      <= fd_d;
    end
  end

  assign load_if.load_ready = ready_q;
  assign dig_en     = sel_q & ~blank_mask;
  assign frame_done = fd_q;
  assign S0 = nib_q[0];
  assign S1 = nib_q[1];
  assign S2 = nib_q[2];
  assign S3 = nib_q[3];

endmodule
